// File: rtl/mem_access_unit.sv
// Load/store sequencer between the memory stage and a big-endian,
// byte-addressed data memory. It accepts one request at a time. Sub-word
// stores become a read-modify-write pair. Loads are lane-extracted and
// then sign- or zero-extended. Misaligned, out-of-range and illegal-size
// requests are answered with resp_err and never touch memory.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; no memory access
// RD      | Mem_r high; capture load result or merge word for RMW
// WR      | Mem_w high; merged or full word written (DM commits at negedge)
// RESP    | one-cycle resp_valid pulse, then back to IDLE
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Mem_addr,
  output logic [31:0] Mem_w_data,
  output logic        Mem_w,
  output logic        Mem_r,
  input  logic [31:0] Mem_r_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] req_align;
  logic        req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] wr_word;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign Mem_addr   = addr_q;
  assign Mem_r      = (state_q == ST_RD);
  assign Mem_w      = (state_q == ST_WR);
  assign Mem_w_data = (state_q == ST_WR) ? wr_word : 32'h0;

  // Request legality: illegal size, misalignment, or a word beyond the DM.
  always_comb begin
    req_align = {req_addr[31:2], 2'b00};
    req_bad   = (req_size == 2'b11)
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
             || ((req_size == 2'b01) && req_addr[0])
             || (req_align >= MEM_LIMIT);
  end

  // Big-endian lane extraction and extension of the read word for loads.
  always_comb begin
    lane_byte = 8'h00;
    case (off_q)
      2'd0:    lane_byte = Mem_r_data[31:24];
      2'd1:    lane_byte = Mem_r_data[23:16];
      2'd2:    lane_byte = Mem_r_data[15:8];
      default: lane_byte = Mem_r_data[7:0];
    endcase
    lane_half = off_q[1] ? Mem_r_data[15:0] : Mem_r_data[31:16];
    load_data = Mem_r_data;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = Mem_r_data;
    endcase
  end

  // Store word: addressed lane replaced in the merge word, or full word.
  always_comb begin
    wr_word = merge_q;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    wr_word[31:24] = wdata_q[7:0];
          2'd1:    wr_word[23:16] = wdata_q[7:0];
          2'd2:    wr_word[15:8]  = wdata_q[7:0];
          default: wr_word[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (off_q[1]) wr_word[15:0]  = wdata_q[15:0];
        else          wr_word[31:16] = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  // Sequencer next-state; response registers only change on entry to RESP.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          addr_d  = req_align;
          if (req_bad) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = ST_RESP;
          end else if (!req_we || (req_size != 2'b10)) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD: begin
        if (we_q) begin
          merge_d = Mem_r_data;
          state_d = ST_WR;
        end else begin
          rdata_d = load_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset drops Mem_r/Mem_w at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= 32'h0;
      addr_q  <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus random
// requests scored against a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Mem_addr;
  logic [31:0] Mem_w_data;
  logic        Mem_w;
  logic        Mem_r;
  logic [31:0] Mem_r_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] dm [0:127];
  logic [7:0] ref_mem [0:127];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .Mem_addr(Mem_addr), .Mem_w_data(Mem_w_data),
    .Mem_w(Mem_w), .Mem_r(Mem_r), .Mem_r_data(Mem_r_data)
  );

  // Data memory: combinational big-endian read, write committed at negedge.
  assign Mem_r_data = {dm[{Mem_addr[6:2], 2'd0}], dm[{Mem_addr[6:2], 2'd1}],
                       dm[{Mem_addr[6:2], 2'd2}], dm[{Mem_addr[6:2], 2'd3}]};

  always @(negedge clk) begin
    if (Mem_w) begin
      dm[{Mem_addr[6:2], 2'd0}] = Mem_w_data[31:24];
      dm[{Mem_addr[6:2], 2'd1}] = Mem_w_data[23:16];
      dm[{Mem_addr[6:2], 2'd2}] = Mem_w_data[15:8];
      dm[{Mem_addr[6:2], 2'd3}] = Mem_w_data[7:0];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input int a, input logic [7:0] b);
    dm[a] = b;
    ref_mem[a] = b;
  endtask

  // Reference model: applies one request to ref_mem using byte addresses.
  task automatic model_apply(input logic we, input logic [1:0] sz, input logic un,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] e_rd, output logic e_er,
                             output int e_lat, output int e_nr, output int e_nw,
                             output logic [31:0] e_w);
    int i;
    int al;
    logic [15:0] h;
    e_rd = 32'h0; e_w = 32'h0; e_lat = 0; e_nr = 0; e_nw = 0;
    e_er = (sz == 2'b11) || (sz == 2'b10 && a[1:0] != 2'b00) ||
           (sz == 2'b01 && a[0]) || ({a[31:2], 2'b00} >= 32'd128);
    if (e_er) return;
    i  = int'(a[6:0]);
    al = int'({a[6:2], 2'b00});
    if (!we) begin
      e_lat = 1; e_nr = 1;
      if (sz == 2'b10) e_rd = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
      else if (sz == 2'b01) begin
        h = {ref_mem[i], ref_mem[i+1]};
        e_rd = un ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        e_rd = un ? {24'h0, ref_mem[i]} : {{24{ref_mem[i][7]}}, ref_mem[i]};
      end
    end else begin
      e_nw = 1;
      if (sz == 2'b10) begin
        e_lat = 1;
        ref_mem[i] = wd[31:24]; ref_mem[i+1] = wd[23:16];
        ref_mem[i+2] = wd[15:8]; ref_mem[i+3] = wd[7:0];
      end else begin
        e_lat = 2; e_nr = 1;
        if (sz == 2'b01) begin ref_mem[i] = wd[15:8]; ref_mem[i+1] = wd[7:0]; end
        else ref_mem[i] = wd[7:0];
      end
      e_w = {ref_mem[al], ref_mem[al+1], ref_mem[al+2], ref_mem[al+3]};
    end
  endtask

  // Issues one request (called #1 after a posedge) and records what the DUT did.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nr, output int nw, output logic [31:0] wseen,
                        output logic [31:0] aseen);
    int guard;
    req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    aseen = Mem_addr;
    lat = -1; rd = 32'h0; er = 1'b0; nr = 0; nw = 0; wseen = 32'h0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
      if (Mem_r) nr++;
      if (Mem_w) begin nw++; wseen = Mem_w_data; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", req_ready);
    end
    checks++;
    if ({resp_valid, resp_err, Mem_w, Mem_r} !== 4'b0 || resp_rdata !== 32'h0 ||
        Mem_addr !== 32'h0 || Mem_w_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b e=%b w=%b r=%b rd=%h a=%h wd=%h exp all zero",
               resp_valid, resp_err, Mem_w, Mem_r, resp_rdata, Mem_addr, Mem_w_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load;
    int lat, nr, nw, elat, enr, enw;
    logic [31:0] rd, ws, as, erd, ew;
    logic er, eer;
    poke(16, 8'h11); poke(17, 8'h22); poke(18, 8'h33); poke(19, 8'h44);
    model_apply(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, erd, eer, elat, enr, enw, ew);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nr, nw, ws, as);
    checks++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      failures++;
      $display("FAIL lw_data got=%h err=%b exp=11223344 err=0", rd, er);
    end
    checks++;
    if (lat !== 1 || nr !== 1 || nw !== 0) begin
      failures++;
      $display("FAIL lw_timing got lat=%0d rd=%0d wr=%0d exp lat=1 rd=1 wr=0", lat, nr, nw);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h11223344) begin
      failures++;
      $display("FAIL lw_pulse_hold got valid=%b rdata=%h exp valid=0 rdata=11223344",
               resp_valid, resp_rdata);
    end
  endtask

  task automatic test_extension;
    int lat, nr, nw, elat, enr, enw;
    logic [31:0] rd, ws, as, erd, ew;
    logic er, eer;
    logic [31:0] exp_v [4];
    logic [31:0] adr [4];
    logic [1:0]  sz [4];
    logic        un [4];
    poke(33, 8'h80); poke(34, 8'hF0); poke(35, 8'h0F);
    exp_v[0] = 32'hFFFFFF80; adr[0] = 32'h21; sz[0] = 2'b00; un[0] = 1'b0;
    exp_v[1] = 32'h00000080; adr[1] = 32'h21; sz[1] = 2'b00; un[1] = 1'b1;
    exp_v[2] = 32'hFFFFF00F; adr[2] = 32'h22; sz[2] = 2'b01; un[2] = 1'b0;
    exp_v[3] = 32'h0000F00F; adr[3] = 32'h22; sz[3] = 2'b01; un[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      model_apply(1'b0, sz[t], un[t], adr[t], 32'h0, erd, eer, elat, enr, enw, ew);
      do_req(1'b0, sz[t], un[t], adr[t], 32'h0, lat, rd, er, nr, nw, ws, as);
      checks++;
      if (rd !== exp_v[t] || er !== 1'b0 || lat !== 1) begin
        failures++;
        $display("FAIL ext_%0d got=%h err=%b lat=%0d exp=%h err=0 lat=1",
                 t, rd, er, lat, exp_v[t]);
      end
    end
  endtask

  task automatic test_rmw;
    int lat, nr, nw, elat, enr, enw;
    logic [31:0] rd, ws, as, erd, ew;
    logic er, eer;
    poke(48, 8'hAA); poke(49, 8'hBB); poke(50, 8'hCC); poke(51, 8'hDD);
    model_apply(1'b1, 2'b00, 1'b0, 32'h31, 32'h12, erd, eer, elat, enr, enw, ew);
    do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h12, lat, rd, er, nr, nw, ws, as);
    checks++;
    if (ws !== 32'hAA12CCDD || nr !== 1 || nw !== 1) begin
      failures++;
      $display("FAIL sb_rmw got wdata=%h rd=%0d wr=%0d exp wdata=aa12ccdd rd=1 wr=1", ws, nr, nw);
    end
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || as !== 32'h30) begin
      failures++;
      $display("FAIL sb_resp got lat=%0d err=%b rdata=%h addr=%h exp lat=2 err=0 rdata=0 addr=30",
               lat, er, rd, as);
    end
    model_apply(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, erd, eer, elat, enr, enw, ew);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er, nr, nw, ws, as);
    checks++;
    if (rd !== 32'hAA12CCDD) begin
      failures++;
      $display("FAIL sb_readback got=%h exp=aa12ccdd", rd);
    end
  endtask

  task automatic test_errors;
    int lat, nr, nw, elat, enr, enw;
    logic [31:0] rd, ws, as, erd, ew;
    logic er, eer;
    logic        we_t [6];
    logic [1:0]  sz_t [6];
    logic [31:0] a_t [6];
    logic        bad_t [6];
    we_t[0] = 1'b0; sz_t[0] = 2'b10; a_t[0] = 32'h06; bad_t[0] = 1'b1;
    we_t[1] = 1'b1; sz_t[1] = 2'b01; a_t[1] = 32'h05; bad_t[1] = 1'b1;
    we_t[2] = 1'b0; sz_t[2] = 2'b11; a_t[2] = 32'h08; bad_t[2] = 1'b1;
    we_t[3] = 1'b0; sz_t[3] = 2'b10; a_t[3] = 32'h80; bad_t[3] = 1'b1;
    we_t[4] = 1'b0; sz_t[4] = 2'b00; a_t[4] = 32'h7F; bad_t[4] = 1'b0;
    we_t[5] = 1'b0; sz_t[5] = 2'b10; a_t[5] = 32'h7C; bad_t[5] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      model_apply(we_t[t], sz_t[t], 1'b0, a_t[t], 32'h5A5A5A5A, erd, eer, elat, enr, enw, ew);
      do_req(we_t[t], sz_t[t], 1'b0, a_t[t], 32'h5A5A5A5A, lat, rd, er, nr, nw, ws, as);
      checks++;
      if (er !== bad_t[t] || (bad_t[t] && (rd !== 32'h0 || nr != 0 || nw != 0 || lat != 0)) ||
          (!bad_t[t] && (rd !== erd || lat != 1))) begin
        failures++;
        $display("FAIL err_case_%0d got err=%b rdata=%h rd=%0d wr=%0d lat=%0d exp err=%b rdata=%h",
                 t, er, rd, nr, nw, lat, bad_t[t], erd);
      end
    end
  endtask

  task automatic test_back_to_back;
    int elat, enr, enw;
    logic [31:0] erd, ew;
    logic eer;
    int guard;
    guard = 0;
    while (!req_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    model_apply(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, erd, eer, elat, enr, enw, ew);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (Mem_w !== 1'b1 || Mem_w_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL b2b_sw_write got w=%b wdata=%h exp w=1 wdata=deadbeef", Mem_w, Mem_w_data);
    end
    req_we = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_sw_resp got valid=%b err=%b ready=%b exp 1 0 0", resp_valid, resp_err, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || Mem_r !== 1'b0) begin
      failures++;
      $display("FAIL b2b_not_accepted_in_resp got ready=%b rd=%b exp ready=1 rd=0", req_ready, Mem_r);
    end
    model_apply(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, erd, eer, elat, enr, enw, ew);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (Mem_r !== 1'b1 || Mem_addr !== 32'h40) begin
      failures++;
      $display("FAIL b2b_lw_accept got rd=%b addr=%h exp rd=1 addr=40", Mem_r, Mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL b2b_lw_data got valid=%b rdata=%h exp valid=1 rdata=deadbeef", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_reset_mid_store;
    int guard;
    poke(80, 8'h01); poke(81, 8'h02); poke(82, 8'h03); poke(83, 8'h04);
    guard = 0;
    while (!req_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h50;
    req_wdata = 32'h000000EE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Mem_w !== 1'b1) begin
      failures++;
      $display("FAIL mid_store_in_wr got w=%b exp=1", Mem_w);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (Mem_w !== 1'b0 || Mem_r !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        resp_rdata !== 32'h0 || resp_err !== 1'b0 || Mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_store_reset got w=%b r=%b ready=%b valid=%b rdata=%h err=%b addr=%h exp 0 0 1 0 0 0 0",
               Mem_w, Mem_r, req_ready, resp_valid, resp_rdata, resp_err, Mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({dm[80], dm[81], dm[82], dm[83]} !== 32'h01020304) begin
      failures++;
      $display("FAIL mid_store_mem got=%h exp=01020304", {dm[80], dm[81], dm[82], dm[83]});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_store_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_random;
    int lat, nr, nw, elat, enr, enw, bad;
    logic [31:0] rd, ws, as, erd, ew, a, wd;
    logic er, eer, we, un;
    logic [1:0] sz;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 139));
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'b10) ? 2'b00 : (sz == 2'b01 ? {a[1], 1'b0} : a[1:0]);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      wd = $urandom;
      model_apply(we, sz, un, a, wd, erd, eer, elat, enr, enw, ew);
      do_req(we, sz, un, a, wd, lat, rd, er, nr, nw, ws, as);
      checks++;
      if (rd !== erd || er !== eer || lat != elat || nr != enr || nw != enw ||
          (enw != 0 && ws !== ew) || as !== {a[31:2], 2'b00}) begin
        failures++;
        $display("FAIL rand_%0d we=%b sz=%0d un=%b a=%h got rd=%h err=%b lat=%0d r=%0d w=%0d wdata=%h addr=%h exp rd=%h err=%b lat=%0d r=%0d w=%0d wdata=%h",
                 n, we, sz, un, a, rd, er, lat, nr, nw, ws, as, erd, eer, elat, enr, enw, ew);
      end
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (dm[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_mem_image got %0d differing bytes exp 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) poke(i, 8'($urandom));
    test_reset();
    test_word_load();
    test_extension();
    test_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
